// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit for RV64M (and W variants): shift-add
// multiply, restoring divide, with a fast path for divide-by-zero and signed overflow.
module mdu_iter #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [TAGW-1:0] tag_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_o,
  output logic            busy
);
  // Handshake: a request transfers on the edge where valid_i && ready_o (and no
  // flush); a result transfers on the edge where valid_o && ready_i; result/tag_o
  // hold while valid_o is high.
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]        r_op;
  logic [TAGW-1:0]   r_tag;
  logic [CW-1:0]     r_cnt;
  logic              r_negp, r_sq, r_sr;
  logic [2*XLEN-1:0] r_prod, r_mcand;
  logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_dvsr, r_result;

  function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] v);
    fit = w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  // Acceptance-time decode on the N-bit operands
  logic            w_w, w_sgn_a, w_sgn_b, w_sa, w_sb, w_is_div, w_is_rem;
  logic            w_fast_dz, w_fast_ov, w_fast, w_accept, w_negp;
  logic [XLEN-1:0] w_mask, w_min, w_a_n, w_b_n, w_mag_a, w_mag_b, w_fast_res;

  assign w_w       = op[3] && (XLEN == 64);
  assign w_mask    = w_w ? XLEN'(32'hFFFF_FFFF) : '1;
  assign w_min     = w_w ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign w_a_n     = a & w_mask;
  assign w_b_n     = b & w_mask;
  assign w_sgn_a   = (op[2:0] == 3'd1) || (op[2:0] == 3'd2) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
  assign w_sgn_b   = (op[2:0] == 3'd1) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
  assign w_sa      = w_sgn_a && (w_w ? a[31] : a[XLEN-1]);
  assign w_sb      = w_sgn_b && (w_w ? b[31] : b[XLEN-1]);
  assign w_mag_a   = (w_sa ? -w_a_n : w_a_n) & w_mask;
  assign w_mag_b   = (w_sb ? -w_b_n : w_b_n) & w_mask;
  assign w_is_div  = op[2];
  assign w_is_rem  = op[1];
  assign w_negp    = (op[2:0] == 3'd1) ? (w_sa ^ w_sb) : (op[2:0] == 3'd2) ? w_sa : 1'b0;
  assign w_fast_dz = w_is_div && (w_b_n == '0);
  assign w_fast_ov = w_is_div && !op[0] && (w_a_n == w_min) && (w_b_n == w_mask);
  assign w_fast    = w_fast_dz || w_fast_ov;
  assign w_accept  = (r_state == S_IDLE) && valid_i && !flush;

  always_comb begin
    w_fast_res = '0;
    if (w_fast_dz) w_fast_res = w_is_rem ? fit(w_w, w_a_n) : fit(w_w, w_mask);
    else           w_fast_res = w_is_rem ? '0 : fit(w_w, w_a_n);
  end

  // One iteration step of both datapaths; the divider reads dividend bit N-1
  logic              r_w, w_top, w_qbit, w_last;
  logic [XLEN:0]     w_rem_sh, w_rem_try;
  logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt, w_q_fin, w_r_fin, w_res_fin;
  logic [2*XLEN-1:0] w_prod_nxt, w_p_fin;

  assign r_w        = r_op[3];
  assign w_prod_nxt = r_mplier[0] ? r_prod + r_mcand : r_prod;
  assign w_top      = r_w ? r_quo[31] : r_quo[XLEN-1];
  assign w_rem_sh   = {r_rem, w_top};
  assign w_rem_try  = w_rem_sh - {1'b0, r_dvsr};
  assign w_qbit     = !w_rem_try[XLEN];
  assign w_rem_nxt  = w_qbit ? w_rem_try[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt  = {r_quo[XLEN-2:0], w_qbit};
  assign w_p_fin    = r_negp ? -w_prod_nxt : w_prod_nxt;
  assign w_q_fin    = r_sq ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fin    = r_sr ? -w_rem_nxt : w_rem_nxt;
  assign w_last     = r_cnt == (r_w ? CW'(31) : CW'(XLEN-1));

  always_comb begin
    w_res_fin = '0;
    if (r_op[2])              w_res_fin = r_op[1] ? fit(r_w, w_r_fin) : fit(r_w, w_q_fin);
    else if (r_op[1:0] == 2'd0) w_res_fin = fit(r_w, w_p_fin[XLEN-1:0]);
    else                      w_res_fin = w_p_fin[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (valid_i) w_state_nxt = w_fast ? S_DONE : S_BUSY;
      S_BUSY: if (w_last)  w_state_nxt = S_DONE;
      S_DONE: if (ready_i) w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_comb begin
    ready_o = (r_state == S_IDLE);
    valid_o = (r_state == S_DONE);
    busy    = (r_state != S_IDLE);
    result  = r_result;
    tag_o   = r_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0; r_tag <= '0; r_cnt <= '0;
      r_negp <= 1'b0; r_sq <= 1'b0; r_sr <= 1'b0;
      r_prod <= '0; r_mcand <= '0; r_mplier <= '0;
      r_rem <= '0; r_quo <= '0; r_dvsr <= '0; r_result <= '0;
    end else if (w_accept) begin
      r_op     <= {w_w, op[2:0]};
      r_tag    <= tag_i;
      r_cnt    <= '0;
      r_negp   <= w_negp;
      r_sq     <= w_sa ^ w_sb;
      r_sr     <= w_sa;
      r_prod   <= '0;
      r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_rem    <= '0;
      r_quo    <= w_mag_a;
      r_dvsr   <= w_mag_b;
      if (w_fast) r_result <= w_fast_res;
    end else if (r_state == S_BUSY) begin
      r_cnt    <= r_cnt + CW'(1);
      r_prod   <= w_prod_nxt;
      r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      if (w_last) r_result <= w_res_fin;
    end
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the execute stage, implementing the RV64M ops and their W-suffixed (32-bit) variants.
- Sits beside the single-cycle ALU in execute. The pipeline holds the M-type instruction in execute while `busy` is high, and consumes the result through a valid/ready handshake.
- Radix-2 design: shift-add multiplication and restoring division, one bit per cycle.
- Special division cases complete on a fast path.

Parameters:
- XLEN, 64: operand/result width. Legal values are 32 and 64; W ops exist only when XLEN=64.
- TAGW, 5: width of the sideband tag (destination register) carried from request to response.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  abort any in-flight or completed operation; no response is produced for it
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request (high only in IDLE)
- op  in  4  {w, funct3}. funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU. w=1 selects the 32-bit variant; only funct3 0, 4, 5, 6, 7 are legal with w=1.
- a  in  XLEN  operand rs1
- b  in  XLEN  operand rs2
- tag_i  in  TAGW  sideband, returned unchanged on tag_o
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result  out  XLEN  result value
- tag_o  out  TAGW  tag of the current result
- busy  out  1  high in BUSY or DONE, i.e. whenever the unit is not in IDLE

Behaviour:
- Clocking: single clock `clk`; `reset` is synchronous and active-high.
- Reset: state=IDLE; valid_o=0, ready_o=1, busy=0, result=0, tag_o=0; counter and internal registers cleared.
- States:
  - IDLE -> BUSY on valid_i&&ready_o, unless the fast path applies.
  - IDLE -> DONE on acceptance when the fast path applies.
  - BUSY -> DONE when the iteration counter reaches N-1.
  - DONE -> IDLE on valid_o&&ready_i.
- Width N: N=XLEN normally; N=32 when w=1.
- Acceptance (cycle 0, captured at the edge ending it):
  - Latch op and tag.
  - For w=1, take a[31:0] and b[31:0] only.
  - Signed operands are converted to magnitudes; the result-sign flags are latched.
  - Counter is set to 0.
- Signedness by op:
  - MULH: a and b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM, DIVW, REMW: signed.
  - MUL: low half is sign-independent.
- Multiply:
  - 2N-bit product register, one shift-add step per cycle for N cycles.
  - At the end, negate the 2N-bit product if the sign flag is set.
  - MUL returns the low N bits; MULH/MULHSU/MULHU return the high N bits.
- Divide:
  - Restoring, one quotient bit per cycle for N cycles.
  - Quotient sign = sa^sb. Remainder sign = sign of dividend.
- W variants: result is the 32-bit value sign-extended to XLEN. This holds for DIVUW and REMUW too.
- Latency:
  - Normal path: cycles 1..N are BUSY; valid_o first high in cycle N+1. That is 65 for 64-bit ops and 33 for W ops.
  - Fast path: valid_o high in cycle 1.
- Fast path, decided at acceptance on the N-bit operands:
  - Divide by zero: quotient = all ones (N bits, then sign-extended if w); remainder = dividend.
  - Signed overflow (dividend = -2^(N-1), divisor = -1): quotient = dividend; remainder = 0.
- Output handshake:
  - result and tag_o are stable while valid_o=1 and ready_i=0; they hold indefinitely.
  - The transfer completes on the cycle valid_o&&ready_i. The next cycle is IDLE with ready_o=1.
  - No new request is accepted in the same cycle as the result transfer.
- Flush:
  - Synchronous; state -> IDLE and valid_o -> 0 on the next edge, from any state.
  - Flush has priority over valid_i in IDLE, so no request is accepted in a flush cycle.
  - Flush has priority over ready_i in DONE; the result is dropped.
- Reset mid-operation has the same effect as reset from idle; all outputs return to their reset values.
- valid_i while not ready_o is ignored; the requester must hold its request.
- Illegal op (w=1 with MULH, MULHSU or MULHU): result is undefined but must still complete with the normal-path latency. The handshake must never lock up.

Test Plan:
- MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3), ready_i=1 -> valid_o in cycle 65, result=0xFFFF_FFFF_FFFF_FFEB, tag_o=tag_i.
- MULHU a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> result=1. MULH with the same operands -> result=0xFFFF_FFFF_FFFF_FFFF.
- DIV 5/0 -> result=0xFFFF_FFFF_FFFF_FFFF. REM 5/0 -> result=5. Both with valid_o in cycle 1.
- DIV 0x8000_0000_0000_0000 / -1 -> result=0x8000_0000_0000_0000. REM with the same operands -> 0. Both on the fast path.
- DIVW a=-7, b=2 -> result=0xFFFF_FFFF_FFFF_FFFD, valid_o in cycle 33. REMW with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVU 100/7 with ready_i held low for 5 cycles after valid_o -> result=14 held stable throughout. Then:
  - flush asserted in cycle 10 of a following DIV -> valid_o never rises; ready_o=1 in the next cycle.
  - reset asserted in BUSY -> all outputs return to their reset values.
